// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer.
// Holds FSM state encoding, requester IDs and bus widths.
package mem_seq_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WORD0 = 2'd1,
    ST_WORD1 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  // Half-word sent in the first memory cycle: high half of a 32-bit write (big-endian).
  function automatic logic [DATA_W-1:0] first_word(input logic [31:0] wdata,
                                                   input logic        en32);
    logic [DATA_W-1:0] w;
    if (en32) begin
      w = wdata[31:16];
    end else begin
      w = wdata[15:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_seq_arbiter.sv
// Grant selection between pipeline port A and exception port B.
// MEM_SEQ_RR_EN selects round-robin; otherwise B has fixed priority.
module mem_seq_arbiter
  import mem_seq_pkg::*;
(
`ifdef MEM_SEQ_RR_EN
  input  logic     clk,
  input  logic     rst_n,
`endif
  input  logic     a_req,
  input  logic     b_req,
  input  logic     enable,
  output port_id_t grant
);

  logic     a_s;
  logic     b_s;
  port_id_t grant_s;

  assign a_s   = a_req & enable;
  assign b_s   = b_req & enable;
  assign grant = grant_s;

`ifdef MEM_SEQ_RR_EN
  port_id_t last_r;

  // Contested cycles go to the port that was not served last.
  always_comb begin
    grant_s = PORT_A;
    if (a_s && b_s) begin
      grant_s = (last_r == PORT_A) ? PORT_B : PORT_A;
    end else if (b_s) begin
      grant_s = PORT_B;
    end else begin
      grant_s = PORT_A;
    end
  end

  // Remember the most recently granted port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= PORT_A;
    end else if (a_s || b_s) begin
      last_r <= grant_s;
    end else begin
      last_r <= last_r;
    end
  end
`else
  // Exception push unit always wins.
  always_comb begin
    grant_s = PORT_A;
    if (b_s) begin
      grant_s = PORT_B;
    end else begin
      grant_s = PORT_A;
    end
  end
`endif

endmodule

// File: rtl/mem_access_sequencer.sv
// Two-requester sequencer splitting 16/32-bit accesses onto a 16-bit memory.
// Define MEM_SEQ_RR_EN for round-robin arbitration instead of B-priority.
module mem_access_sequencer
  import mem_seq_pkg::*;
(
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_a_req,
  input  logic              i_b_req,
  input  logic              i_a_we,
  input  logic              i_b_we,
  input  logic              i_a_en32,
  input  logic              i_b_en32,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [31:0]       i_a_wdata,
  input  logic [31:0]       i_b_wdata,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_a_done,
  output logic              o_b_done,
  output logic [31:0]       o_rdata,
  output logic              o_a_stall
);

  state_t              state_r;
  port_id_t            grant_r;
  logic                we_r;
  logic                en32_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_lo_r;
  logic [DATA_W-1:0]   rdata_hi_r;

  port_id_t            grant_s;
  logic                idle_s;
  logic                any_req_s;
  logic                win_we_s;
  logic                win_en32_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [31:0]         win_wdata_s;

  assign idle_s    = (state_r == ST_IDLE);
  assign any_req_s = i_a_req | i_b_req;
  assign o_a_stall = i_a_req & ~o_a_done;

  mem_seq_arbiter u_arbiter (
`ifdef MEM_SEQ_RR_EN
    .clk    (clk),
    .rst_n  (i_reset_n),
`endif
    .a_req  (i_a_req),
    .b_req  (i_b_req),
    .enable (idle_s),
    .grant  (grant_s)
  );

  // Operand mux for the arbitration winner.
  always_comb begin
    win_we_s    = 1'b0;
    win_en32_s  = 1'b0;
    win_addr_s  = 32'd0;
    win_wdata_s = 32'd0;
    if (grant_s == PORT_B) begin
      win_we_s    = i_b_we;
      win_en32_s  = i_b_en32;
      win_addr_s  = i_b_addr;
      win_wdata_s = i_b_wdata;
    end else begin
      win_we_s    = i_a_we;
      win_en32_s  = i_a_en32;
      win_addr_s  = i_a_addr;
      win_wdata_s = i_a_wdata;
    end
  end

  // Sequencer FSM; bus outputs are registered on entry to each state.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r     <= ST_IDLE;
      grant_r     <= PORT_A;
      we_r        <= 1'b0;
      en32_r      <= 1'b0;
      addr_r      <= 32'd0;
      wdata_lo_r  <= 16'd0;
      rdata_hi_r  <= 16'd0;
      o_mem_rd    <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_addr  <= 32'd0;
      o_mem_wdata <= 16'd0;
      o_a_done    <= 1'b0;
      o_b_done    <= 1'b0;
      o_rdata     <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_a_done <= 1'b0;
          o_b_done <= 1'b0;
          o_rdata  <= 32'd0;
          if (any_req_s) begin
            state_r     <= ST_WORD0;
            grant_r     <= grant_s;
            we_r        <= win_we_s;
            en32_r      <= win_en32_s;
            addr_r      <= win_addr_s;
            wdata_lo_r  <= win_wdata_s[15:0];
            o_mem_rd    <= ~win_we_s;
            o_mem_wr    <= win_we_s;
            o_mem_addr  <= win_addr_s;
            o_mem_wdata <= win_we_s ? first_word(win_wdata_s, win_en32_s) : 16'd0;
          end else begin
            state_r     <= ST_IDLE;
            o_mem_rd    <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 16'd0;
          end
        end
        ST_WORD0: begin
          rdata_hi_r <= i_mem_rdata;
          if (en32_r) begin
            state_r     <= ST_WORD1;
            o_mem_rd    <= ~we_r;
            o_mem_wr    <= we_r;
            o_mem_addr  <= addr_r + 32'd1;
            o_mem_wdata <= we_r ? wdata_lo_r : 16'd0;
          end else begin
            state_r     <= ST_RESP;
            o_mem_rd    <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 16'd0;
            o_a_done    <= (grant_r == PORT_A);
            o_b_done    <= (grant_r == PORT_B);
            o_rdata     <= we_r ? 32'd0 : {16'd0, i_mem_rdata};
          end
        end
        ST_WORD1: begin
          state_r     <= ST_RESP;
          o_mem_rd    <= 1'b0;
          o_mem_wr    <= 1'b0;
          o_mem_addr  <= 32'd0;
          o_mem_wdata <= 16'd0;
          o_a_done    <= (grant_r == PORT_A);
          o_b_done    <= (grant_r == PORT_B);
          o_rdata     <= we_r ? 32'd0 : {rdata_hi_r, i_mem_rdata};
        end
        ST_RESP: begin
          state_r  <= ST_IDLE;
          o_a_done <= 1'b0;
          o_b_done <= 1'b0;
          o_rdata  <= 32'd0;
        end
        default: begin
          state_r     <= ST_IDLE;
          o_mem_rd    <= 1'b0;
          o_mem_wr    <= 1'b0;
          o_mem_addr  <= 32'd0;
          o_mem_wdata <= 16'd0;
          o_a_done    <= 1'b0;
          o_b_done    <= 1'b0;
          o_rdata     <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer; follows MEM_SEQ_RR_EN if defined.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_a_req = 1'b0, i_b_req = 1'b0;
  logic        i_a_we = 1'b0, i_b_we = 1'b0;
  logic        i_a_en32 = 1'b0, i_b_en32 = 1'b0;
  logic [31:0] i_a_addr = 32'd0, i_b_addr = 32'd0;
  logic [31:0] i_a_wdata = 32'd0, i_b_wdata = 32'd0;
  logic        o_mem_rd, o_mem_wr;
  logic [31:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        o_a_done, o_b_done;
  logic [31:0] o_rdata;
  logic        o_a_stall;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [15:0] wdata;
  } mem_op_t;

  typedef struct {
    port_id_t    port;
    logic        rd;
    logic [31:0] rdata;
  } done_t;

  mem_op_t mem_q[$];
  done_t   done_q[$];
  int      n_cmp = 0;
  int      n_err = 0;
`ifdef MEM_SEQ_RR_EN
  port_id_t last_m = PORT_A;
`endif

  always #5 clk = ~clk;

  mem_access_sequencer dut (
    .clk         (clk),
    .i_reset_n   (i_reset_n),
    .i_a_req     (i_a_req),
    .i_b_req     (i_b_req),
    .i_a_we      (i_a_we),
    .i_b_we      (i_b_we),
    .i_a_en32    (i_a_en32),
    .i_b_en32    (i_b_en32),
    .i_a_addr    (i_a_addr),
    .i_b_addr    (i_b_addr),
    .i_a_wdata   (i_a_wdata),
    .i_b_wdata   (i_b_wdata),
    .o_mem_rd    (o_mem_rd),
    .o_mem_wr    (o_mem_wr),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_a_done    (o_a_done),
    .o_b_done    (o_b_done),
    .o_rdata     (o_rdata),
    .o_a_stall   (o_a_stall)
  );

  // Memory contents: fixed pattern, with 0x1234 planted at 0x20.
  function automatic logic [15:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0000_0020) return 16'h1234;
    return a[15:0] ^ a[31:16] ^ 16'hA5C3;
  endfunction

  assign i_mem_rdata = mem_fn(o_mem_addr);

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic port_id_t predict(input logic a, input logic b);
    port_id_t w;
    w = b ? PORT_B : PORT_A;
`ifdef MEM_SEQ_RR_EN
    if (a && b) w = (last_m == PORT_A) ? PORT_B : PORT_A;
    last_m = w;
`endif
    return w;
  endfunction

  task automatic reset_model();
`ifdef MEM_SEQ_RR_EN
    last_m = PORT_A;
`endif
    mem_q.delete();
    done_q.delete();
  endtask

  task automatic expect_txn(input port_id_t p, input logic we, input logic en32,
                            input logic [31:0] addr, input logic [31:0] wd);
    mem_op_t     op;
    done_t       d;
    logic [31:0] a1;
    a1       = addr + 32'd1;
    op.we    = we;
    op.addr  = addr;
    op.wdata = en32 ? wd[31:16] : wd[15:0];
    mem_q.push_back(op);
    if (en32) begin
      op.addr  = a1;
      op.wdata = wd[15:0];
      mem_q.push_back(op);
    end
    d.port  = p;
    d.rd    = !we;
    d.rdata = en32 ? {mem_fn(addr), mem_fn(a1)} : {16'h0000, mem_fn(addr)};
    done_q.push_back(d);
  endtask

  task automatic set_port(input port_id_t p, input logic req, input logic we, input logic en32,
                          input logic [31:0] addr, input logic [31:0] wd);
    if (p == PORT_A) begin
      i_a_req = req; i_a_we = we; i_a_en32 = en32; i_a_addr = addr; i_a_wdata = wd;
    end else begin
      i_b_req = req; i_b_we = we; i_b_en32 = en32; i_b_addr = addr; i_b_wdata = wd;
    end
  endtask

  task automatic wait_done(input port_id_t p, input int exp_lat, input logic chk_stall,
                           input string tag);
    int   k    = 0;
    logic seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      if (chk_stall) check_val({tag, "_stall"}, o_a_stall, (k < exp_lat));
      seen = (p == PORT_A) ? o_a_done : o_b_done;
    end
    check_val({tag, "_latency"}, seen ? k : 999, exp_lat);
  endtask

  task automatic single(input port_id_t p, input logic we, input logic en32,
                        input logic [31:0] addr, input logic [31:0] wd, input string tag);
    port_id_t w;
    @(negedge clk);
    w = predict(p == PORT_A, p == PORT_B);
    expect_txn(w, we, en32, addr, wd);
    set_port(p, 1'b1, we, en32, addr, wd);
    wait_done(p, en32 ? 3 : 2, p == PORT_A, tag);
    set_port(p, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    mem_op_t op;
    done_t   d;
    if (o_mem_rd || o_mem_wr) begin
      check_val("strobe_excl", o_mem_rd & o_mem_wr, 1'b0);
      if (mem_q.size() == 0) begin
        check_val("mem_unexpected", 1'b1, 1'b0);
      end else begin
        op = mem_q.pop_front();
        check_val("mem_wr", o_mem_wr, op.we);
        check_val("mem_addr", o_mem_addr, op.addr);
        if (op.we) check_val("mem_wdata", o_mem_wdata, op.wdata);
      end
    end else begin
      check_val("idle_bus", {o_mem_addr, o_mem_wdata}, 48'd0);
    end
    if (o_a_done || o_b_done) begin
      check_val("done_excl", o_a_done & o_b_done, 1'b0);
      if (done_q.size() == 0) begin
        check_val("done_unexpected", 1'b1, 1'b0);
      end else begin
        d = done_q.pop_front();
        check_val("done_port", o_b_done, (d.port == PORT_B));
        if (d.rd) check_val("rdata", o_rdata, d.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1);
  end

  initial begin
    port_id_t w;
    port_id_t rp;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_strobes", {o_mem_rd, o_mem_wr, o_a_done, o_b_done}, 4'd0);
    check_val("rst_bus", {o_mem_addr, o_mem_wdata}, 48'd0);
    check_val("rst_rdata", o_rdata, 32'd0);
    @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk);

    // Both ports requesting for four back-to-back transactions.
    @(negedge clk);
    set_port(PORT_A, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 32'd0);
    set_port(PORT_B, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_5555);
    for (int i = 0; i < 4; i++) begin
      w = predict(1'b1, 1'b1);
      if (w == PORT_A) expect_txn(w, 1'b0, 1'b1, 32'h0000_0100, 32'd0);
      else             expect_txn(w, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_5555);
      wait_done(w, ((w == PORT_A) ? 3 : 2) + ((i > 0) ? 1 : 0), 1'b0, "arb");
    end
    set_port(PORT_A, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_port(PORT_B, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);

    single(PORT_A, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "wr32");
    single(PORT_A, 1'b0, 1'b0, 32'h0000_0020, 32'd0, "rd16");
    single(PORT_B, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, "rd32_wrap");
    single(PORT_B, 1'b1, 1'b0, 32'h1234_5678, 32'hCAFE_F00D, "wr16");

    // B arrives while A sits in WORD0.
    @(negedge clk);
    w = predict(1'b1, 1'b0);
    expect_txn(w, 1'b0, 1'b0, 32'h0000_0300, 32'd0);
    set_port(PORT_A, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'd0);
    @(posedge clk);
    #1;
    check_val("late_a_stall0", o_a_stall, 1'b1);
    set_port(PORT_B, 1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'd0);
    wait_done(PORT_A, 1, 1'b1, "late_a");
    set_port(PORT_A, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    w = predict(1'b0, 1'b1);
    expect_txn(w, 1'b0, 1'b1, 32'h0000_0400, 32'd0);
    wait_done(PORT_B, 4, 1'b0, "late_b");
    set_port(PORT_B, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);

    // Reset during WORD1 of a 32-bit read.
    @(negedge clk);
    w = predict(1'b1, 1'b0);
    expect_txn(w, 1'b0, 1'b1, 32'h0000_0500, 32'd0);
    set_port(PORT_A, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("pre_rst_word1", {o_mem_rd, o_mem_addr}, {1'b1, 32'h0000_0501});
    i_reset_n = 1'b0;
    #1;
    check_val("rst_mid_strobes", {o_mem_rd, o_mem_wr}, 2'd0);
    check_val("rst_mid_addr", o_mem_addr, 32'd0);
    set_port(PORT_A, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_mid_done", {o_a_done, o_b_done}, 2'd0);
    @(negedge clk);
    i_reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rst_state", dut.state_r, ST_IDLE);

    for (int i = 0; i < 16; i++) begin
      logic        rwe, r32;
      logic [31:0] ra, rd;
      rp  = ($urandom_range(0, 1) == 1) ? PORT_B : PORT_A;
      rwe = 1'($urandom_range(0, 1));
      r32 = 1'($urandom_range(0, 1));
      ra  = (i == 0) ? 32'hFFFF_FFFF : $urandom();
      rd  = $urandom();
      single(rp, rwe, r32, ra, rd, "rnd");
    end

    repeat (2) @(posedge clk);
    #1;
    check_val("mem_q_drained", mem_q.size(), 0);
    check_val("done_q_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
